// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit: shift-add multiply or restoring divide over WIDTH
// iterations, then a sign-fix cycle that writes the HI/LO pair.
module alu_muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t                 state_reg, state_next;
    logic [CW-1:0]          count_reg;
    logic [2*WIDTH-1:0]     acc_reg;
    logic [WIDTH-1:0]       operand_reg;
    logic                   is_div_reg, sign_a_reg, neg_reg, zero_div_reg;
    logic [WIDTH-1:0]       hi_reg, lo_reg;
    logic                   done_reg, div_by_zero_reg;

    logic                   valid_funct, op_signed, op_div;
    logic [WIDTH-1:0]       mag_a, mag_b;
    logic [WIDTH:0]         mul_sum, rem_shift, trial_diff;
    logic [2*WIDTH-1:0]     mul_step, div_step, product_fixed;
    logic [WIDTH-1:0]       quot_fixed, rem_fixed;

    assign valid_funct = (funct[5:2] == 4'b0110);
    assign op_signed   = ~funct[0];
    assign op_div      = funct[1];
    assign mag_a       = (op_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    assign mag_b       = (op_signed && op_b[WIDTH-1]) ? -op_b : op_b;

    // Multiply: upper half accumulates the multiplicand, carry shifts in from the top.
    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                      (acc_reg[0] ? {1'b0, operand_reg} : {(WIDTH+1){1'b0}});
    assign mul_step = {mul_sum, acc_reg[WIDTH-1:1]};

    // Restoring divide: acc holds {remainder, quotient-in-progress}.
    assign rem_shift  = acc_reg[2*WIDTH-1:WIDTH-1];
    assign trial_diff = rem_shift - {1'b0, operand_reg};
    assign div_step   = trial_diff[WIDTH]
                      ? {rem_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                      : {trial_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};

    assign product_fixed = neg_reg ? -acc_reg : acc_reg;
    assign quot_fixed    = neg_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    assign rem_fixed     = sign_a_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start && valid_funct) state_next = RUN;
            RUN:  if (count_reg == CW'(WIDTH - 1)) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_reg != IDLE);
        done        = done_reg;
        div_by_zero = div_by_zero_reg;
        hi          = hi_reg;
        lo          = lo_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg       <= '0;
            acc_reg         <= '0;
            operand_reg     <= '0;
            is_div_reg      <= 1'b0;
            sign_a_reg      <= 1'b0;
            neg_reg         <= 1'b0;
            zero_div_reg    <= 1'b0;
            hi_reg          <= '0;
            lo_reg          <= '0;
            done_reg        <= 1'b0;
            div_by_zero_reg <= 1'b0;
        end else begin
            done_reg        <= 1'b0;
            div_by_zero_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && valid_funct) begin
                        count_reg    <= '0;
                        is_div_reg   <= op_div;
                        sign_a_reg   <= op_signed & op_a[WIDTH-1];
                        neg_reg      <= op_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        zero_div_reg <= op_div & (op_b == '0);
                        // Multiply adds |a| under control of |b|; divide divides |a| by |b|.
                        operand_reg  <= op_div ? mag_b : mag_a;
                        acc_reg      <= {{WIDTH{1'b0}}, op_div ? mag_a : mag_b};
                    end
                end
                RUN: begin
                    count_reg <= count_reg + 1'b1;
                    acc_reg   <= is_div_reg ? div_step : mul_step;
                end
                FIX: begin
                    done_reg <= 1'b1;
                    if (!is_div_reg) begin
                        hi_reg <= product_fixed[2*WIDTH-1:WIDTH];
                        lo_reg <= product_fixed[WIDTH-1:0];
                    end else if (zero_div_reg) begin
                        div_by_zero_reg <= 1'b1;
                    end else begin
                        hi_reg <= rem_fixed;
                        lo_reg <= quot_fixed;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Directed bench for alu_muldiv_sequencer: latency, sign rules, divide-by-zero,
// back-to-back starts, ignored starts, mid-operation reset and illegal funct.
module tb_alu_muldiv_sequencer;
    localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV = 6'b011010, F_DIVU = 6'b011011;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [5:0]  funct = '0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;
    int          n_pass = 0, n_total = 0;

    alu_muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .funct(funct), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Issues one op (start seen at edge E0) and waits for done; samples on negedges.
    // lat counts negedges after E0+0.5 until done; busy_n counts busy samples before it.
    task automatic do_op(input logic now, input logic [5:0] f, input logic [31:0] a, b,
                         output int lat, output int busy_n);
        if (!now) @(negedge clk);
        start = 1'b1; funct = f; op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0; op_a = 32'h1234_5678; op_b = 32'h0000_0003;
        lat = 0; busy_n = 0;
        while (!done && lat < 100) begin
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        #1;
        n_total++; if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) $display("FAIL reset_flags busy=%b done=%b dbz=%b want 000", busy, done, div_by_zero); else n_pass++;
        n_total++; if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL reset_hilo hi=%h lo=%h want 0/0", hi, lo); else n_pass++;
        @(negedge clk); reset = 1'b0;
        $display("reset: busy=%b hi=%h lo=%h", busy, hi, lo);
    endtask

    task automatic test_multu_max();
        int lat, bn;
        do_op(1'b0, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bn);
        n_total++; if (lat !== 33) $display("FAIL multu_latency got=%0d want 33", lat); else n_pass++;
        n_total++; if (bn !== 33) $display("FAIL multu_busy_cycles got=%0d want 33", bn); else n_pass++;
        n_total++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) $display("FAIL multu_result hi=%h lo=%h want fffffffe/00000001", hi, lo); else n_pass++;
        n_total++; if (busy !== 1'b0 || div_by_zero !== 1'b0) $display("FAIL multu_done_flags busy=%b dbz=%b want 0/0", busy, div_by_zero); else n_pass++;
        @(negedge clk);
        n_total++; if (done !== 1'b0) $display("FAIL multu_done_pulse done=%b want 0", done); else n_pass++;
        $display("MULTU ffffffff*ffffffff: lat=%0d hi=%h lo=%h", lat, hi, lo);
    endtask

    task automatic test_mult_signed();
        int lat, bn;
        do_op(1'b0, F_MULT, 32'hFFFF_FFFD, 32'd7, lat, bn);
        n_total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) $display("FAIL mult_neg hi=%h lo=%h want ffffffff/ffffffeb", hi, lo); else n_pass++;
        $display("MULT -3*7: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_div_signed();
        int lat, bn;
        do_op(1'b0, F_DIV, 32'hFFFF_FFF9, 32'd2, lat, bn);
        n_total++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) $display("FAIL div_neg lo=%h hi=%h want fffffffd/ffffffff", lo, hi); else n_pass++;
        $display("DIV -7/2: lo=%h hi=%h", lo, hi);
        do_op(1'b0, F_DIVU, 32'd100, 32'd7, lat, bn);
        n_total++; if (lo !== 32'd14 || hi !== 32'd2) $display("FAIL divu_basic lo=%h hi=%h want 0000000e/00000002", lo, hi); else n_pass++;
        $display("DIVU 100/7: lo=%h hi=%h", lo, hi);
    endtask

    task automatic test_div_by_zero();
        int lat, bn;
        do_op(1'b0, F_DIVU, 32'd100, 32'd0, lat, bn);
        n_total++; if (done !== 1'b1 || div_by_zero !== 1'b1) $display("FAIL dbz_flag done=%b dbz=%b want 1/1", done, div_by_zero); else n_pass++;
        n_total++; if (bn !== 33) $display("FAIL dbz_busy_cycles got=%0d want 33", bn); else n_pass++;
        n_total++; if (lo !== 32'd14 || hi !== 32'd2) $display("FAIL dbz_hilo_kept lo=%h hi=%h want 0000000e/00000002", lo, hi); else n_pass++;
        @(negedge clk);
        n_total++; if (div_by_zero !== 1'b0 || done !== 1'b0) $display("FAIL dbz_pulse dbz=%b done=%b want 0/0", div_by_zero, done); else n_pass++;
        $display("DIVU 100/0: dbz seen, lo=%h hi=%h", lo, hi);
    endtask

    task automatic test_back_to_back();
        int lat, bn;
        do_op(1'b0, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bn);
        n_total++; if (lo !== 32'h8000_0000 || hi !== 32'h0) $display("FAIL div_overflow lo=%h hi=%h want 80000000/00000000", lo, hi); else n_pass++;
        $display("DIV 80000000/ffffffff: lo=%h hi=%h", lo, hi);
        do_op(1'b1, F_MULTU, 32'd6, 32'd9, lat, bn);
        n_total++; if (lat !== 33 || hi !== 32'h0 || lo !== 32'd54) $display("FAIL back_to_back lat=%0d hi=%h lo=%h want 33/00000000/00000036", lat, hi, lo); else n_pass++;
        $display("back-to-back MULTU 6*9: lat=%0d lo=%h", lat, lo);
    endtask

    task automatic test_ignored_start();
        int lat;
        @(negedge clk);
        start = 1'b1; funct = F_MULTU; op_a = 32'd1000; op_b = 32'd1000;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; funct = F_DIVU; op_a = 32'd5; op_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        lat = 5;
        while (!done && lat < 100) begin @(negedge clk); lat++; end
        n_total++; if (lat !== 33 || hi !== 32'h0 || lo !== 32'd1000000) $display("FAIL ignored_start lat=%0d hi=%h lo=%h want 33/00000000/000f4240", lat, hi, lo); else n_pass++;
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL ignored_start_queued busy=%b want 0", busy); else n_pass++;
        $display("ignored start: lat=%0d lo=%h", lat, lo);
    endtask

    task automatic test_reset_abort();
        int seen;
        @(negedge clk);
        start = 1'b1; funct = F_MULT; op_a = 32'd3; op_b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        n_total++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) $display("FAIL reset_abort busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo); else n_pass++;
        @(negedge clk); reset = 1'b0;
        seen = 0;
        repeat (40) begin @(negedge clk); if (done) seen++; end
        n_total++; if (seen !== 0 || busy !== 1'b0) $display("FAIL reset_no_done done_pulses=%0d busy=%b want 0/0", seen, busy); else n_pass++;
        $display("reset abort: busy=%b hi=%h lo=%h", busy, hi, lo);
    endtask

    task automatic test_bad_funct();
        int seen;
        @(negedge clk);
        start = 1'b1; funct = 6'b100000; op_a = 32'd1; op_b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL bad_funct_busy busy=%b want 0", busy); else n_pass++;
        seen = 0;
        repeat (40) begin @(negedge clk); if (done || busy) seen++; end
        n_total++; if (seen !== 0) $display("FAIL bad_funct_activity cycles=%0d want 0", seen); else n_pass++;
        $display("funct 100000: busy=%b", busy);
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_div_signed();
        test_div_by_zero();
        test_back_to_back();
        test_ignored_start();
        test_reset_abort();
        test_bad_funct();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
